load_store_buffer: RTL

In-order load/store buffer sitting between dispatch, the ROB and MemCtrl. It is the responder end of the ROB's `LSB_commit` handshake. It queues memory ops in program order and resolves their base and store-data operands by snooping the ALU, LSB and Branch CDBs. Each head op accesses memory only after the ROB grants it a commit. The op's result is then returned on the LSB CDB so the ROB can mark its tag ready.

---
 rtl/load_store_buffer_pkg.sv | 62 ++++++
 rtl/load_store_buffer_if.sv | 68 ++++++
 rtl/load_store_buffer_load_extend.sv | 25 ++
 rtl/load_store_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer: geometry, op and length codes,
// the queue entry layout and small op-decode helpers.
package load_store_buffer_pkg;

  localparam int unsigned LSB_SIZE = 16;         // entry count, power of two
  localparam int unsigned IDX_W    = 4;          // log2(LSB_SIZE)
  localparam int unsigned TAG_W    = 4;          // ROB tag width
  localparam int unsigned CNT_W    = IDX_W + 1;  // occupancy 0..LSB_SIZE

  localparam logic Valid   = 1'b1;
  localparam logic Invalid = 1'b0;

  typedef logic [TAG_W-1:0] tag_bus_t;  // ROB tag
  typedef logic [IDX_W-1:0] lsb_bus_t;  // queue index
  typedef logic [CNT_W-1:0] lsb_cnt_t;  // occupancy / pending grants

  // Memory op codes: bit 3 marks a store, bits 1:0 encode the access size.
  localparam logic [3:0] OpLb  = 4'h0;
  localparam logic [3:0] OpLh  = 4'h1;
  localparam logic [3:0] OpLw  = 4'h2;
  localparam logic [3:0] OpLbu = 4'h4;
  localparam logic [3:0] OpLhu = 4'h5;
  localparam logic [3:0] OpSb  = 4'h8;
  localparam logic [3:0] OpSh  = 4'h9;
  localparam logic [3:0] OpSw  = 4'hA;

  // MemCtrl length codes
  localparam logic [1:0] LenByte = 2'd0;
  localparam logic [1:0] LenHalf = 2'd1;
  localparam logic [1:0] LenWord = 2'd3;

  typedef enum logic [0:0] {StIdle, StReq} lsb_state_e;

  typedef struct packed {
    logic        busy;
    logic [3:0]  op;
    tag_bus_t    tag;
    logic [31:0] imm;
    logic [31:0] base;
    tag_bus_t    base_tag;
    logic        base_rdy;
    logic [31:0] data;
    tag_bus_t    data_tag;
    logic        data_rdy;
    logic        committed;
  } lsb_entry_t;

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic [1:0] op_len(input logic [3:0] op);
    logic [1:0] len;
    case (op[1:0])
      2'b00:   len = LenByte;
      2'b01:   len = LenHalf;
      default: len = LenWord;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/load_store_buffer_if.sv
// Bus bundle around the load/store buffer: dispatch enqueue, ROB commit grant,
// ALU/Branch CDB snoop, MemCtrl request/response and the LSB CDB broadcast.
// slave  : the load/store buffer side.
// master : the environment (dispatch, ROB, CDBs, MemCtrl).
interface load_store_buffer_if;
  import load_store_buffer_pkg::*;

  logic        rob_commit;

  logic        dispatch_valid;
  logic [3:0]  dispatch_op;
  tag_bus_t    dispatch_tag;
  logic [31:0] dispatch_imm;
  logic        dispatch_reg1_valid;
  logic [31:0] dispatch_reg1_data;
  tag_bus_t    dispatch_reg1_tag;
  logic        dispatch_reg2_valid;
  logic [31:0] dispatch_reg2_data;
  tag_bus_t    dispatch_reg2_tag;

  logic        alu_cdb_valid;
  tag_bus_t    alu_cdb_tag;
  logic [31:0] alu_cdb_data;
  logic        branch_cdb_valid;
  tag_bus_t    branch_cdb_tag;
  logic [31:0] branch_cdb_data;

  logic        id_lsb_is_full;

  logic        memctrl_valid;
  logic        memctrl_wr;
  logic [31:0] memctrl_addr;
  logic [1:0]  memctrl_len;
  logic [31:0] memctrl_wdata;
  logic        memctrl_done;
  logic [31:0] memctrl_rdata;

  logic        lsb_cdb_valid;
  tag_bus_t    lsb_cdb_tag;
  logic [31:0] lsb_cdb_data;

  modport slave (
    input  rob_commit,
    input  dispatch_valid, dispatch_op, dispatch_tag, dispatch_imm,
    input  dispatch_reg1_valid, dispatch_reg1_data, dispatch_reg1_tag,
    input  dispatch_reg2_valid, dispatch_reg2_data, dispatch_reg2_tag,
    input  alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
    input  branch_cdb_valid, branch_cdb_tag, branch_cdb_data,
    output id_lsb_is_full,
    output memctrl_valid, memctrl_wr, memctrl_addr, memctrl_len, memctrl_wdata,
    input  memctrl_done, memctrl_rdata,
    output lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data
  );

  modport master (
    output rob_commit,
    output dispatch_valid, dispatch_op, dispatch_tag, dispatch_imm,
    output dispatch_reg1_valid, dispatch_reg1_data, dispatch_reg1_tag,
    output dispatch_reg2_valid, dispatch_reg2_data, dispatch_reg2_tag,
    output alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
    output branch_cdb_valid, branch_cdb_tag, branch_cdb_data,
    input  id_lsb_is_full,
    input  memctrl_valid, memctrl_wr, memctrl_addr, memctrl_len, memctrl_wdata,
    output memctrl_done, memctrl_rdata,
    input  lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data
  );

endinterface

// File: rtl/load_store_buffer_load_extend.sv
// Combinational load-result formatter.
// i_op   : memory op code
// i_raw  : raw MemCtrl read data, zero-padded above the access length
// o_data : sign/zero-extended result; 0 for stores
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_op)
      OpLb:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      OpLh:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      OpLw:    o_data = i_raw;
      OpLbu:   o_data = {24'b0, i_raw[7:0]};
      OpLhu:   o_data = {16'b0, i_raw[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store buffer. Queues memory ops in program order, resolves
// base/store-data operands by snooping the ALU, Branch and its own CDB, issues
// the head op to MemCtrl once the ROB has granted it a commit, and broadcasts
// the result on the LSB CDB.
// i_clk   : clock
// i_rst   : synchronous active-high reset
// i_rdy   : global enable, all state holds while low
// i_clear : mispredict flush
// io_lsb  : dispatch / ROB / CDB / MemCtrl bundle (slave side)
module load_store_buffer
  import load_store_buffer_pkg::*;
(
  input logic              i_clk,
  input logic              i_rst,
  input logic              i_rdy,
  input logic              i_clear,
  load_store_buffer_if.slave io_lsb
);

  lsb_entry_t  r_ent [LSB_SIZE];
  lsb_entry_t  w_ent_d [LSB_SIZE];
  lsb_entry_t  w_head;
  lsb_entry_t  w_new;
  lsb_bus_t    r_head, r_tail;
  lsb_cnt_t    r_count, w_count_d;
  lsb_cnt_t    r_commit_cnt, w_commit_cnt_d;
  logic        w_grant_avail, w_scan_stop;
  lsb_state_e  r_state, w_state_d;
  logic        w_issue, w_done, w_enq;

  logic        r_full;
  logic        r_mem_valid, r_mem_wr;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [1:0]  r_mem_len;
  logic        r_cdb_valid;
  tag_bus_t    r_cdb_tag;
  logic [31:0] r_cdb_data;
  // A MemCtrl completion seen while stalled is kept until the enable returns.
  logic        r_done_pend;
  logic [31:0] r_rdata_pend;
  logic [31:0] w_rdata, w_ext_data;

  assign w_head  = r_ent[r_head];
  assign w_enq   = io_lsb.dispatch_valid && (r_count != lsb_cnt_t'(LSB_SIZE));
  assign w_rdata = r_done_pend ? r_rdata_pend : io_lsb.memctrl_rdata;

  // Operand resolution: already valid, else a same-cycle hit on any CDB.
  function automatic logic [32:0] resolve(input logic rdy, input logic [31:0] val,
                                          input tag_bus_t tag);
    if (rdy)                                            return {1'b1, val};
    if (io_lsb.alu_cdb_valid && io_lsb.alu_cdb_tag == tag)       return {1'b1, io_lsb.alu_cdb_data};
    if (r_cdb_valid && r_cdb_tag == tag)                         return {1'b1, r_cdb_data};
    if (io_lsb.branch_cdb_valid && io_lsb.branch_cdb_tag == tag) return {1'b1, io_lsb.branch_cdb_data};
    return {1'b0, val};
  endfunction

  lsb_load_extend u_load_extend (
    .i_op   (w_head.op),
    .i_raw  (w_rdata),
    .o_data (w_ext_data)
  );

  // FSM next state
  always_comb begin
    w_state_d = r_state;
    w_issue   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_head.busy && w_head.committed && w_head.base_rdy && w_head.data_rdy) begin
          w_issue   = 1'b1;
          w_state_d = StReq;
        end
      end
      StReq: begin
        if (io_lsb.memctrl_done || r_done_pend) begin
          w_done    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Queue next state: commit grant, snoop, pop, enqueue
  always_comb begin
    w_ent_d        = r_ent;
    w_grant_avail  = (r_commit_cnt != '0) || io_lsb.rob_commit;
    w_commit_cnt_d = r_commit_cnt + lsb_cnt_t'(io_lsb.rob_commit);
    w_scan_stop    = 1'b0;

    // Grants are consumed by the oldest busy, uncommitted entry only.
    for (int unsigned i = 0; i < LSB_SIZE; i++) begin
      lsb_bus_t idx;
      idx = r_head + lsb_bus_t'(i);
      if (!w_scan_stop && r_ent[idx].busy && !r_ent[idx].committed) begin
        w_scan_stop = 1'b1;
        if (w_grant_avail) begin
          w_ent_d[idx].committed = Valid;
          w_commit_cnt_d         = w_commit_cnt_d - lsb_cnt_t'(1);
        end
      end
    end

    for (int unsigned i = 0; i < LSB_SIZE; i++) begin
      if (r_ent[i].busy) begin
        {w_ent_d[i].base_rdy, w_ent_d[i].base} =
            resolve(r_ent[i].base_rdy, r_ent[i].base, r_ent[i].base_tag);
        {w_ent_d[i].data_rdy, w_ent_d[i].data} =
            resolve(r_ent[i].data_rdy, r_ent[i].data, r_ent[i].data_tag);
      end
    end

    if (w_done) begin
      w_ent_d[r_head].busy      = Invalid;
      w_ent_d[r_head].committed = Invalid;
    end

    w_new           = '0;
    w_new.busy      = Valid;
    w_new.op        = io_lsb.dispatch_op;
    w_new.tag       = io_lsb.dispatch_tag;
    w_new.imm       = io_lsb.dispatch_imm;
    w_new.base_tag  = io_lsb.dispatch_reg1_tag;
    w_new.data_tag  = io_lsb.dispatch_reg2_tag;
    {w_new.base_rdy, w_new.base} = resolve(io_lsb.dispatch_reg1_valid,
                                           io_lsb.dispatch_reg1_data, io_lsb.dispatch_reg1_tag);
    {w_new.data_rdy, w_new.data} = resolve(io_lsb.dispatch_reg2_valid,
                                           io_lsb.dispatch_reg2_data, io_lsb.dispatch_reg2_tag);
    if (!op_is_store(io_lsb.dispatch_op)) w_new.data_rdy = Valid;
    if (w_enq) w_ent_d[r_tail] = w_new;

    w_count_d = r_count + lsb_cnt_t'(w_enq) - lsb_cnt_t'(w_done);
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_state <= StIdle;
    else if (i_clear) r_state <= StIdle;
    else if (i_rdy)   r_state <= w_state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < LSB_SIZE; i++) r_ent[i] <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_commit_cnt <= '0;
      r_full       <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_len    <= '0;
      r_mem_wdata  <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_tag    <= '0;
      r_cdb_data   <= '0;
      r_done_pend  <= 1'b0;
      r_rdata_pend <= '0;
    end else if (i_clear) begin
      for (int unsigned i = 0; i < LSB_SIZE; i++) begin
        r_ent[i].busy      <= Invalid;
        r_ent[i].committed <= Invalid;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_commit_cnt <= '0;
      r_full       <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_cdb_valid  <= 1'b0;
      r_done_pend  <= 1'b0;
    end else if (!i_rdy) begin
      if (r_state == StReq && io_lsb.memctrl_done) begin
        r_done_pend  <= 1'b1;
        r_rdata_pend <= io_lsb.memctrl_rdata;
      end
    end else begin
      r_ent        <= w_ent_d;
      r_head       <= r_head + lsb_bus_t'(w_done);
      r_tail       <= r_tail + lsb_bus_t'(w_enq);
      r_count      <= w_count_d;
      r_commit_cnt <= w_commit_cnt_d;
      // Two-slot margin covers dispatch ops already in flight.
      r_full       <= (w_count_d >= lsb_cnt_t'(LSB_SIZE - 2));
      r_done_pend  <= 1'b0;
      r_cdb_valid  <= w_done;
      if (w_done) begin
        r_cdb_tag  <= w_head.tag;
        r_cdb_data <= w_ext_data;
      end
      if (w_issue) begin
        r_mem_valid <= 1'b1;
        r_mem_wr    <= op_is_store(w_head.op);
        r_mem_addr  <= w_head.base + w_head.imm;
        r_mem_len   <= op_len(w_head.op);
        r_mem_wdata <= w_head.data;
      end else if (w_done) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  assign io_lsb.id_lsb_is_full = r_full;
  assign io_lsb.memctrl_valid  = r_mem_valid;
  assign io_lsb.memctrl_wr     = r_mem_wr;
  assign io_lsb.memctrl_addr   = r_mem_addr;
  assign io_lsb.memctrl_len    = r_mem_len;
  assign io_lsb.memctrl_wdata  = r_mem_wdata;
  assign io_lsb.lsb_cdb_valid  = r_cdb_valid;
  assign io_lsb.lsb_cdb_tag    = r_cdb_tag;
  assign io_lsb.lsb_cdb_data   = r_cdb_data;

endmodule
